// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: valid/ready request intake, programmable
// wait states, then a one-cycle response pulse carrying read data and an error flag.
module data_mem_responder #(
    parameter int    DEPTH       = 256,
    parameter int    WAIT_STATES = 2,
    parameter string INIT_FILE   = ""
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] address,
    input  logic [15:0] writeData,
    output logic        resp_valid,
    output logic [15:0] outputDataRead,
    output logic        error
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]    state;
    logic [3:0]    wait_cnt;
    logic          lat_rd;
    logic          lat_wr;
    logic [15:0]   lat_addr;
    logic [15:0]   lat_wdata;
    logic [15:0]   mem [DEPTH];
    logic          addr_bad;
    logic          cmd_bad;
    logic          commit;
    logic          do_write;
    logic [AW-1:0] idx;

    // Range check on the full address so out-of-range words never alias onto the array.
    assign addr_bad  = ({16'd0, lat_addr} >= 32'(DEPTH));
    assign cmd_bad   = lat_rd && lat_wr;
    assign idx       = lat_addr[AW-1:0];
    assign commit    = (state == RESP);
    assign do_write  = commit && lat_wr && !lat_rd && !addr_bad;
    assign req_ready = (state == IDLE);

    always_ff @(posedge clock) begin
        if (req_valid && req_ready) begin
            lat_rd    <= MemRead;
            lat_wr    <= MemWrite;
            lat_addr  <= address;
            lat_wdata <= writeData;
        end
    end

    always_ff @(posedge clock) begin
        if (do_write) begin
            mem[idx] <= lat_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wait_cnt       <= 4'd0;
            resp_valid     <= 1'b0;
            error          <= 1'b0;
            outputDataRead <= 16'h0000;
        end else begin
            resp_valid <= 1'b0;
            error      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    // Commit edge: write lands in the array and the pulse rises together.
                    state      <= IDLE;
                    resp_valid <= 1'b1;
                    error      <= addr_bad || cmd_bad;
                    if (lat_rd) begin
                        if (addr_bad || cmd_bad) begin
                            outputDataRead <= 16'h0000;
                        end else begin
                            outputDataRead <= mem[idx];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
